uart_tx_scheduler: RTL and testbench

Shares the single UART transmit controller (8N1, 9600 baud at 100 MHz, SEND/DATA/READY handshake) between up to N on-chip requesters, such as score reporter, game-state dump and debug echo. Round-robin arbitration admits bytes into a small FIFO. Multi-byte messages stay atomic: a requester keeps the grant until it presents a byte flagged LAST. A sequencer drains the FIFO into the UART controller, issuing exactly one SEND pulse per byte and waiting for each frame to complete.

---
 rtl/uart_sched_pkg.sv | 19 +
 rtl/uart_byte_fifo.sv | 69 ++++++
 rtl/uart_tx_scheduler.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared types and constants for the UART transmit scheduler
//
// Purpose: sequencer state encoding, FIFO entry width and default sizing
// shared by uart_tx_scheduler and uart_byte_fifo.
package uart_sched_pkg;

  // FIFO entry is {last, data[7:0]}
  localparam int ENTRY_W       = 9;
  localparam int OWNER_W       = 3;
  localparam int N_DEFAULT     = 4;
  localparam int DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE      = 2'd0,
    SEQ_ISSUE     = 2'd1,
    SEQ_WAIT_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - synchronous FIFO holding bytes queued for the UART
//
// Purpose: power-of-two deep FIFO; push is ignored when full, pop is ignored
// when empty, both may happen on the same edge.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (flushes contents)
//   push, push_data write request and entry
//   pop             read request; head is the oldest entry
//   head            entry at the read pointer
//   full, empty     status from the registered count
//   count           number of stored entries
module uart_byte_fifo
  import uart_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one 8N1 UART transmitter
//
// Purpose: arbitrates N byte requesters into a FIFO, keeping multi-byte
// messages atomic, and drains the FIFO into the UART controller with one
// SEND pulse per byte.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req, req_data, req_last per-requester byte offer (byte i in [8i+7:8i])
//   gnt                     one-hot combinational grant; byte written this edge
//   uart_send, uart_data    registered SEND pulse and held DATA to the UART
//   uart_ready              READY from the UART controller
//   busy                    FIFO non-empty or sequencer not idle (registered)
//   owner, locked           requester holding the message lock
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [8*N-1:0]     req_data,
  input  logic [N-1:0]       req_last,
  output logic [N-1:0]       gnt,
  output logic               uart_send,
  output logic [7:0]         uart_data,
  input  logic               uart_ready,
  output logic               busy,
  output logic [OWNER_W-1:0] owner,
  output logic               locked
);

  localparam int CW = $clog2(DEPTH) + 1;

  seq_state_t         state_q, state_d;
  logic               send_q, send_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               locked_q, locked_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;

  logic               gnt_found;
  logic [OWNER_W-1:0] gnt_idx;
  logic [ENTRY_W-1:0] push_entry;
  logic               seq_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               unused_head_last;

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (gnt_found),
    .push_data (push_entry),
    .pop       (seq_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The LAST flag travels with each byte for debug visibility only.
  assign unused_head_last = fifo_head[ENTRY_W-1];

  // Arbiter: no dependence on uart_ready, so a pop on a full FIFO only opens
  // a slot on the following cycle.
  always_comb begin
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    gnt        = '0;
    push_entry = '0;
    if (!fifo_full) begin
      if (locked_q) begin
        // Mid-message: only the owner may continue, everyone else waits.
        for (int i = 0; i < N; i++) begin
          if (req[i] && owner_q == OWNER_W'(i)) begin
            gnt_found = 1'b1;
            gnt_idx   = OWNER_W'(i);
          end
        end
      end else begin
        // Round-robin: k is the distance from ptr, first hit wins.
        for (int k = 0; k < N; k++) begin
          for (int i = 0; i < N; i++) begin
            if (!gnt_found && req[i] && i == (int'(ptr_q) + k) % N) begin
              gnt_found = 1'b1;
              gnt_idx   = OWNER_W'(i);
            end
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (gnt_found && gnt_idx == OWNER_W'(i)) begin
        gnt[i]     = 1'b1;
        push_entry = {req_last[i], req_data[8*i +: 8]};
      end
    end
  end

  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    if (gnt_found) begin
      if (push_entry[ENTRY_W-1]) begin
        locked_d = 1'b0;
        ptr_d    = OWNER_W'((int'(gnt_idx) + 1) % N);
      end else begin
        locked_d = 1'b1;
        owner_d  = gnt_idx;
      end
    end
  end

  // Sequencer: SEND is only ever raised on the IDLE->ISSUE transition, and
  // ISSUE waits for READY to drop so the same frame is never sent twice.
  always_comb begin
    state_d = state_q;
    send_d  = 1'b0;
    data_d  = data_q;
    seq_pop = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty && uart_ready) begin
          send_d  = 1'b1;
          data_d  = fifo_head[7:0];
          seq_pop = 1'b1;
          state_d = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        if (!uart_ready) begin
          state_d = SEQ_WAIT_DONE;
        end
      end
      SEQ_WAIT_DONE: begin
        if (uart_ready) begin
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    busy_d = (fifo_count != '0) || (state_q != SEQ_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEQ_IDLE;
      send_q   <= 1'b0;
      data_q   <= 8'h00;
      busy_q   <= 1'b0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      send_q   <= send_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      ptr_q    <= ptr_d;
    end
  end

  assign uart_send = send_q;
  assign uart_data = data_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 30;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   gnt;
  logic           uart_send;
  logic [7:0]     uart_data;
  logic           uart_ready = 1'b1;
  logic           busy;
  logic [2:0]     owner;
  logic           locked;

  logic           hold_ready = 1'b0;
  int             frame_cnt = 0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [8:0] rq_mem [N][64];
  int         rq_head [N];
  int         rq_tail [N];
  int         acc_cnt [N];
  logic       drv_en;

  logic [7:0] exp_q [$];
  logic       sb_en = 1'b1;
  int         sends_total = 0;
  int         spacing_err = 0;
  int         lock_viol = 0;
  int         gnt0_cycles = 0;
  logic       prev_send = 1'b0;
  logic       saw_low = 1'b0;

  uart_tx_scheduler #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .gnt        (gnt),
    .uart_send  (uart_send),
    .uart_data  (uart_data),
    .uart_ready (uart_ready),
    .busy       (busy),
    .owner      (owner),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // UART controller model: samples SEND, drops READY for FRAME cycles.
  always @(posedge clk) begin
    if (uart_send) frame_cnt <= FRAME;
    else if (frame_cnt != 0) frame_cnt <= frame_cnt - 1;
    uart_ready <= !hold_ready && !uart_send && (frame_cnt <= 1);
  end

  a_send_spacing: assert property (@(posedge clk) disable iff (!rst_n)
    uart_send |-> (!$past(uart_send) && uart_ready));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor and scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (uart_send && (prev_send || !uart_ready)) spacing_err++;
      if (uart_send && sends_total > 0 && !saw_low) spacing_err++;
      if (!uart_ready) saw_low = 1'b1;
      if (gnt != '0 && !$onehot(gnt)) lock_viol++;
      if (gnt != '0 && locked && gnt != (N'(1) << owner)) lock_viol++;
      if (gnt[0]) gnt0_cycles++;
      if (uart_send) begin
        sends_total++;
        saw_low = 1'b0;
        if (sb_en) begin
          if (exp_q.size() == 0) check("line_unexpected", {24'h0, uart_data}, 32'hFFFF_FFFF);
          else check("line_byte", {24'h0, uart_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
    prev_send = uart_send;
  end

  task automatic add_byte(input int r, input logic [7:0] d, input logic l);
    rq_mem[r][rq_tail[r] % 64] = {l, d};
    rq_tail[r]++;
  endtask

  // Requesters: hold each byte until a grant is seen, then present the next.
  task automatic drive_loop();
    logic [N-1:0] take;
    forever begin
      @(negedge clk);
      take = gnt & req;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (take[i] && rq_head[i] != rq_tail[i]) begin
          rq_head[i]++;
          acc_cnt[i]++;
        end
        if (drv_en && rq_head[i] != rq_tail[i]) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = rq_mem[i][rq_head[i] % 64][7:0];
          req_last[i] = rq_mem[i][rq_head[i] % 64][8];
        end else begin
          req[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_sends(input int target, input int budget, input string tag);
    int n = 0;
    while (sends_total < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, sends_total, target);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, a0, n, total, len;
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    req_last = '0;
    drv_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
      acc_cnt[i] = 0;
    end
    fork
      drive_loop();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_gnt", {28'h0, gnt}, 32'h0);
    check("rst_send", {31'h0, uart_send}, 32'h0);
    check("rst_data", {24'h0, uart_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_owner", {29'h0, owner}, 32'h0);
    check("rst_locked", {31'h0, locked}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round robin: all four requesters, two single-byte rounds
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < N; i++) begin
        add_byte(i, 8'h10 + 8'(i), 1'b1);
        exp_q.push_back(8'h10 + 8'(i));
      end
    wait_sends(8, 8 * (FRAME + 10), "rr_sends");
    wait_idle(FRAME + 20, "rr_idle");

    // Single byte with latency check
    gnt0_cycles = 0;
    s0 = sends_total;
    exp_q.push_back(8'h41);
    add_byte(0, 8'h41, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[0] && n < 20);
    check("single_gnt_seen", {31'h0, gnt[0]}, 32'h1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("single_send_k1", {31'h0, uart_send}, 32'h1);
    check("single_data_k1", {24'h0, uart_data}, 32'h41);
    check("single_busy", {31'h0, busy}, 32'h1);
    wait_sends(s0 + 1, FRAME + 20, "single_sends");
    wait_idle(FRAME + 20, "single_idle");
    check("single_gnt_cycles", gnt0_cycles, 1);

    // Message lock: requester 2 sends A0 A1 A2, requester 1 joins mid-message
    s0 = sends_total;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'h55);
    add_byte(2, 8'hA0, 1'b0);
    add_byte(2, 8'hA1, 1'b0);
    add_byte(2, 8'hA2, 1'b1);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!locked && n < 20);
    check("lock_locked", {31'h0, locked}, 32'h1);
    check("lock_owner", {29'h0, owner}, 32'h2);
    add_byte(1, 8'h55, 1'b1);
    wait_sends(s0 + 4, 4 * (FRAME + 10), "lock_sends");
    wait_idle(FRAME + 20, "lock_idle");
    check("lock_released", {31'h0, locked}, 32'h0);

    // Full FIFO: READY held low, 9 bytes offered
    s0 = sends_total;
    a0 = acc_cnt[0];
    hold_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      add_byte(0, 8'h60 + 8'(i), 1'b1);
      exp_q.push_back(8'h60 + 8'(i));
    end
    repeat (20) @(negedge clk);
    check("full_accepted", acc_cnt[0] - a0, 8);
    check("full_gnt_blocked", {28'h0, gnt}, 32'h0);
    check("full_no_send", sends_total - s0, 0);
    hold_ready = 1'b0;
    @(negedge clk);
    check("full_gnt_ignores_ready", {27'h0, uart_ready, gnt}, {27'h0, 1'b1, 4'h0});
    wait_sends(s0 + 9, 9 * (FRAME + 10), "full_sends");
    wait_idle(FRAME + 20, "full_idle");

    // Reset during a 5-byte locked message from requester 3
    s0 = sends_total;
    a0 = acc_cnt[3];
    exp_q.push_back(8'hB0);
    for (int i = 0; i < 5; i++) add_byte(3, 8'hB0 + 8'(i), i == 4);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (acc_cnt[3] - a0 < 3 && n < 20);
    check("rst_mid_accepted", acc_cnt[3] - a0, 3);
    rst_n = 1'b0;
    drv_en = 1'b0;
    req = '0;
    req_last = '0;
    req_data = '0;
    rq_head[3] = rq_tail[3];
    #1;
    check("rst_mid_gnt", {28'h0, gnt}, 32'h0);
    check("rst_mid_send", {31'h0, uart_send}, 32'h0);
    check("rst_mid_data", {24'h0, uart_data}, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_owner", {29'h0, owner}, 32'h0);
    check("rst_mid_locked", {31'h0, locked}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drv_en = 1'b1;
    n = 0;
    while (!uart_ready && n < FRAME + 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("rst_post_sends", sends_total - s0, 1);
    check("rst_post_busy", {31'h0, busy}, 32'h0);
    check("rst_post_locked", {31'h0, locked}, 32'h0);
    exp_q.push_back(8'h77);
    add_byte(0, 8'h77, 1'b1);
    wait_sends(s0 + 2, FRAME + 30, "rst_post_byte");
    wait_idle(FRAME + 20, "rst_post_idle");

    // Random traffic for SEND spacing and lock exclusivity
    sb_en = 1'b0;
    s0 = sends_total;
    total = 0;
    for (int r = 0; r < N; r++)
      for (int m = 0; m < 3; m++) begin
        len = int'($urandom_range(1, 3));
        for (int b = 0; b < len; b++) begin
          add_byte(r, 8'($urandom), b == len - 1);
          total++;
        end
      end
    wait_sends(s0 + total, total * (FRAME + 10) + 200, "rand_sends");
    wait_idle(FRAME + 20, "rand_idle");

    check("send_spacing", spacing_err, 0);
    check("lock_exclusive", lock_viol, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
